// File: rtl/sprite_register_dma.sv
// Vblank-triggered copier from a RAM shadow table to consecutive display registers.
// Optional SPRITE_REGISTER_DMA_OVERRUN_EN adds a saturating count of vblank edges missed while busy.
module sprite_register_dma #(
   parameter int unsigned NUM_REGS   = 16,
   parameter logic [11:0] BASE_INDEX = 12'd0,
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable_i,
   input  logic                  in_vblank_i,
   input  logic [ADDR_WIDTH-1:0] table_base_i,
   output logic                  mem_read_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [15:0]           mem_data_i,
   output logic                  register_write_o,
   output logic [11:0]           register_index_o,
   output logic [15:0]           register_write_value_o,
   output logic                  busy_o,
   output logic                  done_o
`ifdef SPRITE_REGISTER_DMA_OVERRUN_EN
   ,
   input  logic                  clear_overrun_i,
   output logic [7:0]            overrun_count_o
`endif
);

   localparam int unsigned CNT_W = 13;
   localparam logic [CNT_W-1:0] NUM_K = CNT_W'(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  vblank_q, vblank_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [CNT_W-1:0]      rd_k_q, rd_k_d;
   logic [CNT_W-1:0]      wr_k_q, wr_k_d;
   logic                  mem_read_q, mem_read_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  reg_write_q, reg_write_d;
   logic [11:0]           reg_index_q, reg_index_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  vblank_rise_c;
   logic                  start_c;

   assign vblank_rise_c = in_vblank_i & ~vblank_q;
   assign start_c       = vblank_rise_c & enable_i & (state_q == IDLE);

   // rd_k counts reads already issued; the first read is issued on the start edge itself.
   always_comb begin
      state_d     = state_q;
      vblank_d    = in_vblank_i;
      base_d      = base_q;
      rd_k_d      = rd_k_q;
      wr_k_d      = wr_k_q;
      mem_read_d  = 1'b0;
      mem_addr_d  = '0;
      reg_write_d = 1'b0;
      reg_index_d = '0;
      busy_d      = busy_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start_c) begin
               state_d    = RUN;
               base_d     = table_base_i;
               rd_k_d     = CNT_W'(1);
               wr_k_d     = '0;
               mem_read_d = 1'b1;
               mem_addr_d = table_base_i;
               busy_d     = 1'b1;
            end
         end
         RUN: begin
            if (rd_k_q < NUM_K) begin
               mem_read_d = 1'b1;
               mem_addr_d = ADDR_WIDTH'(base_q + rd_k_q);
               rd_k_d     = CNT_W'(rd_k_q + CNT_W'(1));
            end
            // RAM data for a read visible this cycle arrives next cycle, alongside the write strobe.
            if (mem_read_q) begin
               reg_write_d = 1'b1;
               reg_index_d = 12'(BASE_INDEX + wr_k_q);
               wr_k_d      = CNT_W'(wr_k_q + CNT_W'(1));
            end
            if (reg_write_q && (wr_k_q == NUM_K)) begin
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

`ifdef SPRITE_REGISTER_DMA_OVERRUN_EN
   logic [7:0] overrun_q, overrun_d;

   // Clear wins over a simultaneous missed edge; count holds at 255.
   always_comb begin
      overrun_d = overrun_q;
      if (clear_overrun_i) begin
         overrun_d = '0;
      end else if (vblank_rise_c && enable_i && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
         overrun_d = 8'(overrun_q + 8'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_q <= '0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

   assign overrun_count_o = overrun_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         vblank_q    <= 1'b1;
         base_q      <= '0;
         rd_k_q      <= '0;
         wr_k_q      <= '0;
         mem_read_q  <= 1'b0;
         mem_addr_q  <= '0;
         reg_write_q <= 1'b0;
         reg_index_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vblank_q    <= vblank_d;
         base_q      <= base_d;
         rd_k_q      <= rd_k_d;
         wr_k_q      <= wr_k_d;
         mem_read_q  <= mem_read_d;
         mem_addr_q  <= mem_addr_d;
         reg_write_q <= reg_write_d;
         reg_index_q <= reg_index_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mem_read_o       = mem_read_q;
   assign mem_addr_o       = mem_addr_q;
   assign register_write_o = reg_write_q;
   assign register_index_o = reg_index_q;
   // RAM output is already a register stage; it is only gated so idle cycles show zero.
   assign register_write_value_o = reg_write_q ? mem_data_i : 16'd0;
   assign busy_o           = busy_q;
   assign done_o           = done_q;

endmodule

// File: tb/tb_sprite_register_dma.sv
// Scoreboard bench for sprite_register_dma: three instances (4, 16 and 1 registers) with a shared RAM model.
module tb_sprite_register_dma;

   typedef struct {
      int          cyc;
      logic [11:0] a;
      logic [15:0] v;
   } ev_t;

   logic clk;
   logic reset;
   logic en [3];
   logic vb [3];
   logic [11:0] tbase [3];
   logic [15:0] md [3];

   logic mr0, mr1, mr2;
   logic [11:0] ma0, ma1, ma2;
   logic rw0, rw1, rw2;
   logic [11:0] ri0, ri1, ri2;
   logic [15:0] rv0, rv1, rv2;
   logic busy0, busy1, busy2;
   logic done0, done1, done2;
`ifdef SPRITE_REGISTER_DMA_OVERRUN_EN
   logic clr [3];
   logic [7:0] ov0, ov1, ov2;
`endif

   logic [15:0] ram [4096];
   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int wr_cnt [3];
   ev_t rd_q [3][$];
   ev_t wr_q [3][$];
   int  dn_q [3][$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sprite_register_dma #(.NUM_REGS(4), .BASE_INDEX(12'd3), .ADDR_WIDTH(12)) u0 (
      .clk(clk), .reset(reset), .enable_i(en[0]), .in_vblank_i(vb[0]), .table_base_i(tbase[0]),
      .mem_read_o(mr0), .mem_addr_o(ma0), .mem_data_i(md[0]),
      .register_write_o(rw0), .register_index_o(ri0), .register_write_value_o(rv0),
      .busy_o(busy0), .done_o(done0)
`ifdef SPRITE_REGISTER_DMA_OVERRUN_EN
      , .clear_overrun_i(clr[0]), .overrun_count_o(ov0)
`endif
   );

   sprite_register_dma #(.NUM_REGS(16), .BASE_INDEX(12'hFF8), .ADDR_WIDTH(12)) u1 (
      .clk(clk), .reset(reset), .enable_i(en[1]), .in_vblank_i(vb[1]), .table_base_i(tbase[1]),
      .mem_read_o(mr1), .mem_addr_o(ma1), .mem_data_i(md[1]),
      .register_write_o(rw1), .register_index_o(ri1), .register_write_value_o(rv1),
      .busy_o(busy1), .done_o(done1)
`ifdef SPRITE_REGISTER_DMA_OVERRUN_EN
      , .clear_overrun_i(clr[1]), .overrun_count_o(ov1)
`endif
   );

   sprite_register_dma #(.NUM_REGS(1), .BASE_INDEX(12'h7FF), .ADDR_WIDTH(12)) u2 (
      .clk(clk), .reset(reset), .enable_i(en[2]), .in_vblank_i(vb[2]), .table_base_i(tbase[2]),
      .mem_read_o(mr2), .mem_addr_o(ma2), .mem_data_i(md[2]),
      .register_write_o(rw2), .register_index_o(ri2), .register_write_value_o(rv2),
      .busy_o(busy2), .done_o(done2)
`ifdef SPRITE_REGISTER_DMA_OVERRUN_EN
      , .clear_overrun_i(clr[2]), .overrun_count_o(ov2)
`endif
   );

   // Synchronous RAM: data valid the cycle after a read strobe, junk otherwise.
   always @(posedge clk) begin
      md[0] <= mr0 ? ram[ma0] : 16'hDEAD;
      md[1] <= mr1 ? ram[ma1] : 16'hDEAD;
      md[2] <= mr2 ? ram[ma2] : 16'hDEAD;
   end

   // Monitor: pops scoreboard entries as reads, writes and done pulses appear.
   always @(negedge clk) begin
      logic m_r [3];
      logic [11:0] m_a [3];
      logic m_w [3];
      logic [11:0] m_i [3];
      logic [15:0] m_v [3];
      logic m_d [3];
      ev_t e;
      int dc;
      m_r[0] = mr0; m_r[1] = mr1; m_r[2] = mr2;
      m_a[0] = ma0; m_a[1] = ma1; m_a[2] = ma2;
      m_w[0] = rw0; m_w[1] = rw1; m_w[2] = rw2;
      m_i[0] = ri0; m_i[1] = ri1; m_i[2] = ri2;
      m_v[0] = rv0; m_v[1] = rv1; m_v[2] = rv2;
      m_d[0] = done0; m_d[1] = done1; m_d[2] = done2;
      for (int k = 0; k < 3; k++) begin
         while (rd_q[k].size() != 0 && rd_q[k][0].cyc < cyc) begin
            e = rd_q[k].pop_front();
            checks++; failures++;
            $display("FAIL read_missing inst=%0d expected cyc=%0d addr=%h", k, e.cyc, e.a);
         end
         while (wr_q[k].size() != 0 && wr_q[k][0].cyc < cyc) begin
            e = wr_q[k].pop_front();
            checks++; failures++;
            $display("FAIL write_missing inst=%0d expected cyc=%0d idx=%h val=%h", k, e.cyc, e.a, e.v);
         end
         while (dn_q[k].size() != 0 && dn_q[k][0] < cyc) begin
            dc = dn_q[k].pop_front();
            checks++; failures++;
            $display("FAIL done_missing inst=%0d expected cyc=%0d", k, dc);
         end
         if (m_r[k] === 1'b1) begin
            checks++;
            if (rd_q[k].size() == 0) begin
               failures++;
               $display("FAIL read_unexpected inst=%0d cyc=%0d addr=%h", k, cyc, m_a[k]);
            end else begin
               e = rd_q[k].pop_front();
               if (e.cyc !== cyc || e.a !== m_a[k]) begin
                  failures++;
                  $display("FAIL read inst=%0d got cyc=%0d addr=%h want cyc=%0d addr=%h",
                           k, cyc, m_a[k], e.cyc, e.a);
               end
            end
         end
         if (m_w[k] === 1'b1) begin
            wr_cnt[k]++;
            checks++;
            if (wr_q[k].size() == 0) begin
               failures++;
               $display("FAIL write_unexpected inst=%0d cyc=%0d idx=%h val=%h", k, cyc, m_i[k], m_v[k]);
            end else begin
               e = wr_q[k].pop_front();
               if (e.cyc !== cyc || e.a !== m_i[k] || e.v !== m_v[k]) begin
                  failures++;
                  $display("FAIL write inst=%0d got cyc=%0d idx=%h val=%h want cyc=%0d idx=%h val=%h",
                           k, cyc, m_i[k], m_v[k], e.cyc, e.a, e.v);
               end
            end
         end else begin
            checks++;
            if (m_i[k] !== 12'd0 || m_v[k] !== 16'd0) begin
               failures++;
               $display("FAIL idle_zero inst=%0d cyc=%0d idx=%h val=%h want 0", k, cyc, m_i[k], m_v[k]);
            end
         end
         if (m_d[k] === 1'b1) begin
            checks++;
            if (dn_q[k].size() == 0) begin
               failures++;
               $display("FAIL done_unexpected inst=%0d cyc=%0d", k, cyc);
            end else begin
               dc = dn_q[k].pop_front();
               if (dc !== cyc) begin
                  failures++;
                  $display("FAIL done inst=%0d got cyc=%0d want cyc=%0d", k, cyc, dc);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_xfer(input int k, input int t, input logic [11:0] base, input int num,
                            input logic [11:0] bidx, input int n_rd, input int n_wr, input bit with_done);
      ev_t e;
      for (int i = 0; i < n_rd; i++) begin
         e.cyc = t + 1 + i; e.a = 12'(base + i); e.v = 16'd0;
         rd_q[k].push_back(e);
      end
      for (int i = 0; i < n_wr; i++) begin
         e.cyc = t + 2 + i; e.a = 12'(bidx + i); e.v = ram[12'(base + i)];
         wr_q[k].push_back(e);
      end
      if (with_done) dn_q[k].push_back(t + num + 2);
   endtask

   task automatic wait_drain(input int k, input int budget);
      int n = 0;
      while ((rd_q[k].size() != 0 || wr_q[k].size() != 0 || dn_q[k].size() != 0) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL drain_timeout inst=%0d pending rd=%0d wr=%0d done=%0d want 0",
                  k, rd_q[k].size(), wr_q[k].size(), dn_q[k].size());
      end
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         en[k] = 1'b1; vb[k] = 1'b1; tbase[k] = 12'h000;
`ifdef SPRITE_REGISTER_DMA_OVERRUN_EN
         clr[k] = 1'b0;
`endif
      end
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if ({mr0, ma0, rw0, ri0, rv0, busy0, done0} !== '0) begin
         failures++;
         $display("FAIL reset_out inst=0 got %h want 0", {mr0, ma0, rw0, ri0, rv0, busy0, done0});
      end
      checks++;
      if ({mr1, ma1, rw1, ri1, rv1, busy1, done1} !== '0) begin
         failures++;
         $display("FAIL reset_out inst=1 got %h want 0", {mr1, ma1, rw1, ri1, rv1, busy1, done1});
      end
      checks++;
      if ({mr2, ma2, rw2, ri2, rv2, busy2, done2} !== '0) begin
         failures++;
         $display("FAIL reset_out inst=2 got %h want 0", {mr2, ma2, rw2, ri2, rv2, busy2, done2});
      end
`ifdef SPRITE_REGISTER_DMA_OVERRUN_EN
      checks++;
      if ({ov0, ov1, ov2} !== 24'd0) begin
         failures++;
         $display("FAIL reset_overrun got %h want 0", {ov0, ov1, ov2});
      end
`endif
      tick();
      reset = 1'b0;
   endtask

   task automatic test_vblank_held_at_reset();
      repeat (12) tick();
      @(negedge clk);
      checks++;
      if (wr_cnt[0] != 0 || wr_cnt[1] != 0 || wr_cnt[2] != 0 || {busy0, busy1, busy2} !== 3'b000) begin
         failures++;
         $display("FAIL held_vblank writes=%0d/%0d/%0d busy=%b want 0 and 000",
                  wr_cnt[0], wr_cnt[1], wr_cnt[2], {busy0, busy1, busy2});
      end
      tick();
      for (int k = 0; k < 3; k++) vb[k] = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_basic();
      int t, s;
      ram[12'h100] = 16'h00A1; ram[12'h101] = 16'h00B2;
      ram[12'h102] = 16'h00C3; ram[12'h103] = 16'h00D4;
      tbase[0] = 12'h100;
      s = wr_cnt[0];
      tick();
      vb[0] = 1'b1; t = cyc;
      push_xfer(0, t, 12'h100, 4, 12'd3, 4, 4, 1'b1);
      @(negedge clk);
      checks++;
      if (busy0 !== 1'b0) begin
         failures++; $display("FAIL busy_start_cycle got %b want 0", busy0);
      end
      @(negedge clk);
      checks++;
      if (busy0 !== 1'b1) begin
         failures++; $display("FAIL busy_next_cycle got %b want 1", busy0);
      end
      tick();
      vb[0] = 1'b0;
      wait_drain(0, 40);
      checks++;
      if (wr_cnt[0] - s != 4) begin
         failures++; $display("FAIL basic_count got %0d want 4", wr_cnt[0] - s);
      end
   endtask

   task automatic test_wrap_base();
      int t;
      tbase[0] = 12'hFFE;
      tick();
      vb[0] = 1'b1; t = cyc;
      push_xfer(0, t, 12'hFFE, 4, 12'd3, 4, 4, 1'b1);
      repeat (2) tick();
      tbase[0] = 12'h200;
      vb[0] = 1'b0;
      wait_drain(0, 40);
   endtask

   task automatic test_enable();
      int t, s;
      en[0] = 1'b0;
      s = wr_cnt[0];
      tick();
      vb[0] = 1'b1;
      repeat (3) tick();
      vb[0] = 1'b0;
      repeat (8) tick();
      @(negedge clk);
      checks++;
      if (wr_cnt[0] != s || busy0 !== 1'b0) begin
         failures++; $display("FAIL enable_low writes=%0d busy=%b want 0 and 0", wr_cnt[0] - s, busy0);
      end
      tick();
      en[0] = 1'b1;
      tbase[0] = 12'h040;
      tick();
      vb[0] = 1'b1; t = cyc;
      push_xfer(0, t, 12'h040, 4, 12'd3, 4, 4, 1'b1);
      repeat (2) tick();
      en[0] = 1'b0;
      vb[0] = 1'b0;
      wait_drain(0, 40);
      en[0] = 1'b1;
   endtask

   task automatic test_reset_mid();
      int t, s;
      tbase[1] = 12'h300;
      tick();
      vb[1] = 1'b1; t = cyc;
      push_xfer(1, t, 12'h300, 16, 12'hFF8, 6, 5, 1'b0);
      repeat (3) tick();
      vb[1] = 1'b0;
      while (cyc < t + 6) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy1, mr1, rw1, done1} !== 4'b0000) begin
         failures++; $display("FAIL reset_mid busy/rd/wr/done got %b want 0000", {busy1, mr1, rw1, done1});
      end
      wait_drain(1, 10);
      repeat (3) tick();
      s = wr_cnt[1];
      tick();
      vb[1] = 1'b1; t = cyc;
      push_xfer(1, t, 12'h300, 16, 12'hFF8, 16, 16, 1'b1);
      repeat (3) tick();
      vb[1] = 1'b0;
      wait_drain(1, 60);
      checks++;
      if (wr_cnt[1] - s != 16) begin
         failures++; $display("FAIL restart_count got %0d want 16", wr_cnt[1] - s);
      end
   endtask

   task automatic test_back_to_back();
      int t, s;
      tbase[1] = 12'h500;
      s = wr_cnt[1];
      tick();
      vb[1] = 1'b1; t = cyc;
      push_xfer(1, t, 12'h500, 16, 12'hFF8, 16, 16, 1'b1);
      repeat (3) tick();
      vb[1] = 1'b0;
      while (cyc < t + 10) tick();
      vb[1] = 1'b1;
      repeat (3) tick();
      vb[1] = 1'b0;
      wait_drain(1, 60);
      repeat (5) tick();
      checks++;
      if (wr_cnt[1] - s != 16) begin
         failures++; $display("FAIL overlap_count got %0d want 16", wr_cnt[1] - s);
      end
`ifdef SPRITE_REGISTER_DMA_OVERRUN_EN
      checks++;
      if (ov1 !== 8'd1) begin
         failures++; $display("FAIL overrun_one got %0d want 1", ov1);
      end
      clr[1] = 1'b1;
      tick();
      clr[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (ov1 !== 8'd0) begin
         failures++; $display("FAIL overrun_clear got %0d want 0", ov1);
      end
      tick();
`endif
   endtask

   task automatic test_single();
      int t, s;
      tbase[2] = 12'hABC;
      s = wr_cnt[2];
      tick();
      vb[2] = 1'b1; t = cyc;
      push_xfer(2, t, 12'hABC, 1, 12'h7FF, 1, 1, 1'b1);
      tick();
      vb[2] = 1'b0;
      wait_drain(2, 20);
      checks++;
      if (wr_cnt[2] - s != 1) begin
         failures++; $display("FAIL single_count got %0d want 1", wr_cnt[2] - s);
      end
   endtask

`ifdef SPRITE_REGISTER_DMA_OVERRUN_EN
   task automatic test_overrun_saturate();
      int t;
      tbase[1] = 12'h600;
      for (int it = 0; it < 38; it++) begin
         tick();
         vb[1] = 1'b1; t = cyc;
         push_xfer(1, t, 12'h600, 16, 12'hFF8, 16, 16, 1'b1);
         tick();
         vb[1] = 1'b0;
         for (int j = 0; j < 8; j++) begin
            tick(); vb[1] = 1'b1;
            tick(); vb[1] = 1'b0;
         end
         wait_drain(1, 40);
         if (it == 0) begin
            checks++;
            if (ov1 !== 8'd8) begin
               failures++; $display("FAIL overrun_eight got %0d want 8", ov1);
            end
         end
      end
      checks++;
      if (ov1 !== 8'd255) begin
         failures++; $display("FAIL overrun_saturate got %0d want 255", ov1);
      end
   endtask
`endif

   initial begin
      for (int a = 0; a < 4096; a++) ram[a] = 16'(a * 7 + 16'h1234);
      for (int k = 0; k < 3; k++) wr_cnt[k] = 0;
      test_reset();
      test_vblank_held_at_reset();
      test_basic();
      test_wrap_base();
      test_enable();
      test_reset_mid();
      test_back_to_back();
      test_single();
`ifdef SPRITE_REGISTER_DMA_OVERRUN_EN
      test_overrun_saturate();
`endif
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
